// File: rtl/disp_msg_scheduler.sv
// Message scheduler for the 4-digit 7-segment display.
// Gathers UART Rx characters into a buffer, commits them on CR, then shows
// either a static left-justified window or a circular scroll of the message.
module disp_msg_scheduler #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned SCROLL_DIV = 25000000
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       scroll_en,
    output logic [3:0] bcd1,
    output logic [3:0] bcd2,
    output logic [3:0] bcd3,
    output logic [3:0] bcd4,
    output logic [1:0] state,
    output logic [4:0] msg_len,
    output logic       overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(SCROLL_DIV);
    localparam logic [3:0]  BLANK = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RECV = 2'b01,
        S_SHOW = 2'b10
    } state_t;

    state_t          r_state;
    logic [LW-1:0]   r_wptr;
    logic [LW-1:0]   r_len;
    logic [LW-1:0]   r_pos;
    logic [PW-1:0]   r_presc;
    logic            r_ovf;
    logic [15:0]     r_win;
    logic [3:0]      r_buf [DEPTH];

    logic            w_is_char;
    logic            w_is_cr;
    logic [3:0]      w_code;
    logic            w_buf_we;
    logic [AW-1:0]   w_buf_addr;
    logic [LW:0]     w_sum [4];
    logic [15:0]     w_win_show;
    logic [15:0]     w_win_commit;
    logic            w_long;
    logic            w_step;

    // Map the received byte to a display code or a commit request
    always_comb begin
        w_is_char = 1'b0;
        w_is_cr   = 1'b0;
        w_code    = BLANK;
        if (rx_valid) begin
            if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
                w_is_char = 1'b1;
                w_code    = rx_data[3:0];
            end else if (rx_data == 8'h2D) begin
                w_is_char = 1'b1;
                w_code    = 4'hA;
            end else if (rx_data == 8'h20) begin
                w_is_char = 1'b1;
                w_code    = BLANK;
            end else if (rx_data == 8'h0D) begin
                w_is_cr = 1'b1;
            end
        end
    end

    // Buffer write port: slot 0 when a new message starts, else the write pointer
    always_comb begin
        w_buf_we   = 1'b0;
        w_buf_addr = '0;
        if (w_is_char) begin
            if (r_state == S_RECV) begin
                w_buf_we   = (r_wptr < LW'(DEPTH));
                w_buf_addr = AW'(r_wptr);
            end else begin
                w_buf_we   = 1'b1;
                w_buf_addr = '0;
            end
        end
    end

    // Message storage; contents are don't-care until written
    always_ff @(posedge Clk) begin
        if (w_buf_we) begin
            r_buf[w_buf_addr] <= w_code;
        end
    end

    // Display windows: scrolled/padded view of the committed message, and the
    // pos=0 view of the message being committed right now
    always_comb begin
        w_long       = (r_len > LW'(4));
        w_win_show   = {4{BLANK}};
        w_win_commit = {4{BLANK}};
        for (int k = 0; k < 4; k++) begin
            w_sum[k] = {1'b0, r_pos} + (LW+1)'(k);
            if (w_sum[k] >= {1'b0, r_len}) begin
                w_sum[k] = w_sum[k] - {1'b0, r_len};
            end
            if (w_long) begin
                w_win_show[(15 - 4*k) -: 4] = r_buf[AW'(w_sum[k])];
            end else if (LW'(k) < r_len) begin
                w_win_show[(15 - 4*k) -: 4] = r_buf[AW'(k)];
            end
            if (LW'(k) < r_wptr) begin
                w_win_commit[(15 - 4*k) -: 4] = r_buf[AW'(k)];
            end
        end
    end

    // Scroll step strobe: prescaler at terminal count while scrolling is enabled
    always_comb begin
        w_step = scroll_en && w_long && (r_presc == PW'(SCROLL_DIV - 1));
    end

    // Receive / show state machine with registered display outputs
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_wptr  <= '0;
            r_len   <= '0;
            r_pos   <= '0;
            r_presc <= '0;
            r_ovf   <= 1'b0;
            r_win   <= {4{BLANK}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_is_char) begin
                        r_state <= S_RECV;
                        r_wptr  <= LW'(1);
                    end
                end
                S_RECV: begin
                    if (w_is_char) begin
                        if (r_wptr < LW'(DEPTH)) begin
                            r_wptr <= r_wptr + LW'(1);
                        end else begin
                            r_ovf <= 1'b1;
                        end
                    end else if (w_is_cr && (r_wptr != '0)) begin
                        r_len   <= r_wptr;
                        r_pos   <= '0;
                        r_presc <= '0;
                        r_ovf   <= 1'b0;
                        r_win   <= w_win_commit;
                        r_state <= S_SHOW;
                    end
                end
                S_SHOW: begin
                    if (w_is_char) begin
                        // New message preempts any pending scroll step
                        r_state <= S_RECV;
                        r_wptr  <= LW'(1);
                    end else begin
                        r_win <= w_win_show;
                        if (w_step) begin
                            r_presc <= '0;
                            r_pos   <= (r_pos == r_len - LW'(1)) ? '0 : r_pos + LW'(1);
                        end else if (scroll_en && w_long) begin
                            r_presc <= r_presc + PW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Output mapping from registered state
    assign bcd1     = r_win[15:12];
    assign bcd2     = r_win[11:8];
    assign bcd3     = r_win[7:4];
    assign bcd4     = r_win[3:0];
    assign state    = r_state;
    assign msg_len  = 5'(r_len);
    assign overflow = r_ovf;

endmodule

// File: tb/tb_disp_msg_scheduler.sv
// Testbench for disp_msg_scheduler: directed table, hand sequences, and a
// randomized run against a message-level reference model.
module tb_disp_msg_scheduler;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned SD    = 4;

    logic       Clk = 1'b0;
    logic       reset;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       scroll_en;
    logic [3:0] bcd1, bcd2, bcd3, bcd4;
    logic [1:0] state;
    logic [4:0] msg_len;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;

    disp_msg_scheduler #(.DEPTH(DEPTH), .SCROLL_DIV(SD)) dut (
        .Clk      (Clk),
        .reset    (reset),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .scroll_en(scroll_en),
        .bcd1     (bcd1),
        .bcd2     (bcd2),
        .bcd3     (bcd3),
        .bcd4     (bcd4),
        .state    (state),
        .msg_len  (msg_len),
        .overflow (overflow)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [47:0] chars;
        logic [3:0]  n;
        logic [15:0] win;
        logic [4:0]  len;
    } vec_t;

    // ---------------- checking helpers ----------------
    function automatic logic [23:0] act();
        return {bcd1, bcd2, bcd3, bcd4, state, msg_len, overflow};
    endfunction

    function automatic logic [23:0] pk(input logic [15:0] w, input logic [1:0] s,
                                       input logic [4:0] l, input logic o);
        return {w, s, l, o};
    endfunction

    task automatic check(input string nm, input logic [23:0] got, input logic [23:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got bcd=%h st=%b len=%0d ovf=%b, expected bcd=%h st=%b len=%0d ovf=%b",
                     nm, got[23:8], got[7:6], got[5:1], got[0],
                     exp[23:8], exp[7:6], exp[5:1], exp[0]);
        end
    endtask

    task automatic tick();
        @(negedge Clk);
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge Clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic pulse_reset(input string nm);
        reset = 1'b0;
        #2;
        check({nm, "_async"}, act(), pk(16'hFFFF, 2'b00, 5'd0, 1'b0));
        @(negedge Clk);
        reset = 1'b1;
        check(nm, act(), pk(16'hFFFF, 2'b00, 5'd0, 1'b0));
    endtask

    // ---------------- reference model (message level) ----------------
    int          m_mode;
    logic [3:0]  m_q[$];
    logic [3:0]  m_msg[$];
    bit          m_ovf;
    int          m_ticks;
    logic [15:0] m_disp;

    function automatic int map_b(input logic [7:0] d);
        if (d >= 8'h30 && d <= 8'h39) return int'(d) - 48;
        if (d == 8'h2D) return 10;
        if (d == 8'h20) return 15;
        if (d == 8'h0D) return -2;
        return -1;
    endfunction

    function automatic logic [15:0] win_of(input int p);
        logic [15:0] w;
        int L;
        w = 16'hFFFF;
        L = m_msg.size();
        for (int k = 0; k < 4; k++) begin
            if (L > 4)      w[(15 - 4*k) -: 4] = m_msg[(p + k) % L];
            else if (k < L) w[(15 - 4*k) -: 4] = m_msg[k];
        end
        return w;
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_q.delete();
        m_msg.delete();
        m_ovf = 1'b0;
        m_ticks = 0;
        m_disp = 16'hFFFF;
    endtask

    task automatic model_step(input bit v, input logic [7:0] d, input bit se);
        int c;
        int L;
        c = v ? map_b(d) : -1;
        L = m_msg.size();
        case (m_mode)
            0: if (c >= 0) begin
                   m_mode = 1;
                   m_q.delete();
                   m_q.push_back(4'(c));
               end
            1: if (c >= 0) begin
                   if (m_q.size() < int'(DEPTH)) m_q.push_back(4'(c));
                   else m_ovf = 1'b1;
               end else if (c == -2) begin
                   m_msg = m_q;
                   m_ticks = 0;
                   m_ovf = 1'b0;
                   m_mode = 2;
                   m_disp = win_of(0);
               end
            default: if (c >= 0) begin
                   m_mode = 1;
                   m_q.delete();
                   m_q.push_back(4'(c));
               end else begin
                   m_disp = win_of((L > 4) ? (m_ticks / int'(SD)) % L : 0);
                   if (se && L > 4) m_ticks++;
               end
        endcase
    endtask

    function automatic logic [23:0] model_out();
        return pk(m_disp, 2'(m_mode), 5'(m_msg.size()), m_ovf);
    endfunction

    // ---------------- stimulus ----------------
    vec_t        vecs[6];
    logic [15:0] scroll_exp[7];

    initial begin
        reset = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        scroll_en = 1'b1;

        vecs[0] = '{chars: 48'("-194"),  n: 4'd4, win: 16'hA194, len: 5'd4};
        vecs[1] = '{chars: 48'("7"),     n: 4'd1, win: 16'h7FFF, len: 5'd1};
        vecs[2] = '{chars: 48'(" 8 "),   n: 4'd3, win: 16'hF8FF, len: 5'd3};
        vecs[3] = '{chars: 48'("AB9"),   n: 4'd3, win: 16'h9FFF, len: 5'd1};
        vecs[4] = '{chars: 48'("12-34"), n: 4'd5, win: 16'h12A3, len: 5'd5};
        vecs[5] = '{chars: 48'("9999"),  n: 4'd4, win: 16'h9999, len: 5'd4};
        scroll_exp = '{16'h1234, 16'h2345, 16'h3456, 16'h4561, 16'h5612, 16'h6123, 16'h1234};

        // Power-on reset, checked while asserted and after release
        #12;
        check("reset_hold", act(), pk(16'hFFFF, 2'b00, 5'd0, 1'b0));
        @(negedge Clk);
        reset = 1'b1;
        check("reset_release", act(), pk(16'hFFFF, 2'b00, 5'd0, 1'b0));

        // Invalid bytes and CR are ignored in IDLE
        send(8'h00);
        send("A");
        send(8'h0D);
        tick();
        check("idle_ignore", act(), pk(16'hFFFF, 2'b00, 5'd0, 1'b0));

        // Table of short messages, checked one cycle after the CR
        scroll_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            for (int j = int'(vecs[i].n) - 1; j >= 0; j--) send(vecs[i].chars[8*j +: 8]);
            send(8'h0D);
            check($sformatf("table_%0d", i), act(), pk(vecs[i].win, 2'b10, vecs[i].len, 1'b0));
        end

        // Short message never scrolls
        scroll_en = 1'b1;
        send_str("-194");
        send(8'h0D);
        repeat (10 * SD) tick();
        check("short_static", act(), pk(16'hA194, 2'b10, 5'd4, 1'b0));

        // Scrolling with wrap, one step every SD cycles
        send_str("123456");
        send(8'h0D);
        check("scroll_commit", act(), pk(16'h1234, 2'b10, 5'd6, 1'b0));
        tick();
        for (int i = 0; i < 7; i++) begin
            check($sformatf("scroll_%0d", i), act(), pk(scroll_exp[i], 2'b10, 5'd6, 1'b0));
            if (i < 6) repeat (SD) tick();
        end
        scroll_en = 1'b0;
        repeat (12) tick();
        check("scroll_hold", act(), pk(16'h1234, 2'b10, 5'd6, 1'b0));
        scroll_en = 1'b1;
        repeat (SD - 1) tick();
        check("scroll_resume_pre", act(), pk(16'h1234, 2'b10, 5'd6, 1'b0));
        tick();
        check("scroll_resume", act(), pk(16'h2345, 2'b10, 5'd6, 1'b0));

        // Overflow: 18 digits into a 16-entry buffer
        scroll_en = 1'b0;
        for (int i = 0; i < 18; i++) send(8'h30 + 8'(i % 10));
        check("ovf_set", act(), pk(16'h2345, 2'b01, 5'd6, 1'b1));
        send(8'h0D);
        check("ovf_commit", act(), pk(16'h0123, 2'b10, 5'd16, 1'b0));

        // Interrupt a shown message, then a new short message
        send("5");
        check("interrupt", act(), pk(16'h0123, 2'b01, 5'd16, 1'b0));
        send("5");
        send(8'h0D);
        check("interrupt_commit", act(), pk(16'h55FF, 2'b10, 5'd2, 1'b0));

        // Reset in the middle of receiving
        send_str("12");
        check("recv_mid", act(), pk(16'h55FF, 2'b01, 5'd2, 1'b0));
        pulse_reset("reset_recv");

        // Randomized traffic against the reference model
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit         v;
            logic [7:0] d;
            int         r;
            int         pct;
            pct = ((cyc / 80) % 2 == 0) ? 40 : 3;
            v = ($urandom_range(0, 99) < pct);
            r = $urandom_range(0, 99);
            if (r < 80) begin
                r = $urandom_range(0, 11);
                d = (r < 10) ? 8'h30 + 8'(r) : ((r == 10) ? 8'h2D : 8'h20);
            end else if (r < 92) begin
                d = 8'h0D;
            end else begin
                r = $urandom_range(0, 2);
                d = (r == 0) ? 8'h41 : ((r == 1) ? 8'h00 : 8'h7F);
            end
            rx_valid  = v;
            rx_data   = d;
            scroll_en = ($urandom_range(0, 99) < 85);
            model_step(v, d, scroll_en);
            tick();
            check($sformatf("rand_%0d", cyc), act(), model_out());
        end
        rx_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/disp_msg_scheduler.md
Name: disp_msg_scheduler

Overview:
- Sequences the 4-digit multiplexed 7-segment datapath from the UART receive side.
- Collects received ASCII characters into a message buffer and converts them to 4-bit display codes.
- Drives the four digit codes (bcd1 leftmost … bcd4 rightmost) into the segment driver, either as a static window or as a circular scroll at a programmable rate.
- Sits between the UART Rx byte output and the 7-segment TOP digit inputs.

Parameters:
- DEPTH, 16, message buffer entries; power of 2, at least 4.
- SCROLL_DIV, 25000000, Clk cycles per scroll step; at least 2.

Ports:
- Clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low reset.
- rx_valid  in  1  single-cycle strobe: rx_data holds a new received byte.
- rx_data  in  8  received ASCII byte.
- scroll_en  in  1  1 = scrolling runs; 0 = scroll position and prescaler are frozen.
- bcd1  out  4  leftmost digit code.
- bcd2  out  4  digit 2 code.
- bcd3  out  4  digit 3 code.
- bcd4  out  4  rightmost digit code.
- state  out  2  current FSM state: 00 IDLE, 01 RECV, 10 SHOW.
- msg_len  out  5  committed message length, 0..DEPTH.
- overflow  out  1  sticky; set when a character is dropped because the buffer is full.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, write pointer=0, msg_len=0, pos=0, prescaler=0, overflow=0.
  - bcd1..bcd4=4'b1111 (blank code; the segment decoder shows all segments off).
- Character map, applied on rx_valid:
  - '0'..'9' (0x30..0x39) → code 0..9.
  - '-' (0x2D) → 4'b1010.
  - ' ' (0x20) → 4'b1111.
  - CR (0x0D) → commit.
  - Any other byte → ignored; no state change.
- FSM:
  - IDLE: outputs blank. A mapped character goes to RECV, writes buf[0], wptr=1. CR is ignored.
  - RECV:
    - Mapped char with wptr<DEPTH → buf[wptr]=code, wptr+1.
    - Mapped char with wptr==DEPTH → dropped, overflow=1.
    - CR with wptr>0 → msg_len=wptr, pos=0, prescaler=0, overflow=0, go to SHOW.
    - Outputs hold their previous values throughout RECV.
  - SHOW:
    - Mapped char → go to RECV, buf[0]=code, wptr=1. Outputs hold the last window.
    - CR → ignored.
- Window in SHOW: digit k (k=0..3) = buf[(pos+k) mod msg_len] if msg_len>4. If msg_len<=4, digit k = buf[k] for k<msg_len, else blank (left-justified, no scrolling).
- Scroll (msg_len>4 only):
  - Prescaler counts Clk cycles while scroll_en=1.
  - At count SCROLL_DIV-1: prescaler→0, pos→pos+1, with wrap from msg_len-1 to 0.
  - scroll_en=0 holds both prescaler and pos.
- Latency:
  - bcd outputs are registered.
  - New window appears 1 cycle after the CR strobe and 1 cycle after the pos update.
  - First step occurs SCROLL_DIV cycles after entering SHOW.
- Simultaneous events: rx_valid takes priority over a scroll step in the same cycle. On entering RECV, the step is discarded.
- Reset asserted mid-message or mid-scroll returns immediately to the reset values. Buffer contents need no reset.

Test Plan:
- Reset: pulse reset low 10 ns with no rx → bcd1..4=F,F,F,F, state=00, msg_len=0, overflow=0.
- Short message: send "-194",CR → 1 cycle after CR, bcd1..4=A,1,9,4, state=10, msg_len=4. No change after 10×SCROLL_DIV cycles.
- Pad: send "7",CR → bcd=7,F,F,F.
- Scroll with SCROLL_DIV=4: send "123456",CR → windows 1234 → 2345 → 3456 → 4561 → 5612 → 6123 → 1234, one step every 4 cycles. With scroll_en=0 for 12 cycles, the window is held.
- Overflow with DEPTH=16: send 18 digits then CR → overflow=1 before CR, msg_len=16, overflow cleared at commit. Invalid bytes ('A', 0x00) are ignored.
- Interrupt: during SHOW, send '5' → state=01 and outputs frozen. Then send "5",CR → bcd=5,5,F,F. Assert reset mid-RECV → all outputs at reset values.
